mem_access_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the EX-stage ALU. Captures the ALU result, store data and control bits in an EX/MEM register, performs byte/halfword/word loads and stores on an internal data memory, and presents write-back data through a MEM/WB register. Also exports EX/MEM contents to the forwarding unit.

---
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : MIPS MEM stage. EX/MEM pipeline register, byte/half/word
//             load-store on an internal data memory, MEM/WB register, and
//             EX/MEM taps for the forwarding unit.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_stage #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset,          // asynchronous, active low
   input  logic [31:0] outAlu,
   input  logic [31:0] dataRt,
   input  logic [4:0]  rdEx,
   input  logic        regWriteEx,
   input  logic        memReadEx,
   input  logic        memWriteEx,
   input  logic        memToRegEx,
   input  logic [1:0]  memWidthEx,
   input  logic        memUnsignedEx,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] memAluOut,
   output logic [4:0]  memRd,
   output logic        memRegWrite,
   output logic [31:0] wbData,
   output logic [4:0]  wbRd,
   output logic        wbRegWrite,
   output logic        alignErr
);

   localparam logic [1:0] C_W_BYTE = 2'b00;
   localparam logic [1:0] C_W_HALF = 2'b01;

   // EX/MEM register
   logic [31:0] alu_q, alu_d;
   logic [31:0] rt_q, rt_d;
   logic [4:0]  rd_q, rd_d;
   logic        regwr_q, regwr_d;
   logic        memrd_q, memrd_d;
   logic        memwr_q, memwr_d;
   logic        m2r_q, m2r_d;
   logic [1:0]  width_q, width_d;
   logic        uns_q, uns_d;

   // MEM/WB register
   logic [31:0] wbdata_q, wbdata_d;
   logic [4:0]  wbrd_q, wbrd_d;
   logic        wbregwr_q, wbregwr_d;
   logic        alerr_q, alerr_d;

   // Data memory (not reset)
   logic [31:0] mem [DEPTH];

   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_lane;
   logic [31:0]       w_word;
   logic              w_aligned;
   logic              w_misaligned;
   logic              w_we;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic [31:0]       w_wb_value;

   assign w_idx  = alu_q[ADDR_W+1:2];
   assign w_lane = alu_q[1:0];
   assign w_word = mem[w_idx];

   // Alignment, lane enables, store data replication and load extraction
   always_comb begin
      w_aligned = 1'b1;
      w_be      = 4'b1111;
      w_wdata   = rt_q;
      w_byte    = w_word[8*w_lane +: 8];
      w_half    = w_lane[1] ? w_word[31:16] : w_word[15:0];
      w_load    = w_word;
      if (width_q == C_W_BYTE) begin
         w_be    = 4'b0001 << w_lane;
         w_wdata = {4{rt_q[7:0]}};
         w_load  = uns_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end else if (width_q == C_W_HALF) begin
         w_aligned = ~w_lane[0];
         w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
         w_wdata   = {2{rt_q[15:0]}};
         w_load    = uns_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end else begin
         w_aligned = (w_lane == 2'b00);
      end
      w_misaligned = (memrd_q | memwr_q) & ~w_aligned;
      if (w_misaligned) begin
         w_load = 32'h0;
      end
      // reset term makes sure nothing is committed while reset is held
      w_we       = memwr_q & w_aligned & ~stall & reset;
      w_wb_value = m2r_q ? w_load : alu_q;
   end

   // Next state for both pipeline registers: hold on stall, bubble on flush
   always_comb begin
      alu_d     = alu_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      regwr_d   = regwr_q;
      memrd_d   = memrd_q;
      memwr_d   = memwr_q;
      m2r_d     = m2r_q;
      width_d   = width_q;
      uns_d     = uns_q;
      wbdata_d  = wbdata_q;
      wbrd_d    = wbrd_q;
      wbregwr_d = wbregwr_q;
      alerr_d   = alerr_q;
      if (!stall) begin
         if (flush) begin
            alu_d   = 32'h0;
            rt_d    = 32'h0;
            rd_d    = 5'h0;
            regwr_d = 1'b0;
            memrd_d = 1'b0;
            memwr_d = 1'b0;
            m2r_d   = 1'b0;
            width_d = 2'b00;
            uns_d   = 1'b0;
         end else begin
            alu_d   = outAlu;
            rt_d    = dataRt;
            rd_d    = rdEx;
            regwr_d = regWriteEx;
            memrd_d = memReadEx;
            memwr_d = memWriteEx;
            m2r_d   = memToRegEx;
            width_d = memWidthEx;
            uns_d   = memUnsignedEx;
         end
         wbdata_d  = w_wb_value;
         wbrd_d    = rd_q;
         wbregwr_d = regwr_q;
         alerr_d   = w_misaligned;
      end
   end

   // Pipeline registers with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_q     <= 32'h0;
         rt_q      <= 32'h0;
         rd_q      <= 5'h0;
         regwr_q   <= 1'b0;
         memrd_q   <= 1'b0;
         memwr_q   <= 1'b0;
         m2r_q     <= 1'b0;
         width_q   <= 2'b00;
         uns_q     <= 1'b0;
         wbdata_q  <= 32'h0;
         wbrd_q    <= 5'h0;
         wbregwr_q <= 1'b0;
         alerr_q   <= 1'b0;
      end else begin
         alu_q     <= alu_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         regwr_q   <= regwr_d;
         memrd_q   <= memrd_d;
         memwr_q   <= memwr_d;
         m2r_q     <= m2r_d;
         width_q   <= width_d;
         uns_q     <= uns_d;
         wbdata_q  <= wbdata_d;
         wbrd_q    <= wbrd_d;
         wbregwr_q <= wbregwr_d;
         alerr_q   <= alerr_d;
      end
   end

   // Byte-lane memory write; commits as the store leaves EX/MEM
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
               mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
            end
         end
      end
   end

   assign memAluOut   = alu_q;
   assign memRd       = rd_q;
   assign memRegWrite = regwr_q;
   assign wbData      = wbdata_q;
   assign wbRd        = wbrd_q;
   assign wbRegWrite  = wbregwr_q;
   assign alignErr    = alerr_q;

endmodule
`default_nettype wire
